da_bit_tx: RTL and testbench
============================

// Module: da_bit_tx
// PURPOSE
//   Bit-serial front end for distributed-arithmetic (DA) sum-of-product units.
//   Accepts one parallel sample per handshake into an L-tap delay line.
//   Streams the delay line LSB-first, one bit-vector per beat: bit k of the
//   vector is the current bit of tap k, which is the address of the DA table.
//   Sits between the sample source and the DA table/accumulator stage.
// PARAMETERS
//   W  3  sample width in bits = number of beats per sample
//   L  3  number of taps = width of the streamed bit-vector
// PORTS
//   clk      in   1  system clock; all state changes on the rising edge
//   reset    in   1  synchronous reset, active-high
//   clear    in   1  zero the delay line; honoured only in IDLE
//   s_valid  in   1  input sample valid
//   s_ready  out  1  block can accept a sample
//   s_data   in   W  input sample, unsigned or two's complement (raw bits)
//   m_valid  out  1  bit-vector beat valid
//   m_ready  in   1  downstream accepts the beat
//   m_bits   out  L  m_bits[k] = current bit of tap k
//   m_first  out  1  beat carries bit 0 (LSB)
//   m_last   out  1  beat carries bit W-1 (MSB/sign); DA stage subtracts here
//   busy     out  1  high in SEND state
// BEHAVIOUR
//   Interface
//   - One clock (clk). Reset is synchronous and active-high (reset).
//   Reset values (outputs and state)
//   - Taps tap[0..L-1] = 0.
//   - State IDLE.
//   - m_valid = 0, m_bits = 0, m_first = 0, m_last = 0, busy = 0.
//   - s_ready = (state==IDLE) && !reset, so s_ready is 0 while reset is high.
//   State machine (2 states)
//   - IDLE: s_ready=1, m_valid=0.
//     - clear=1: all taps go to 0.
//     - s_valid=1: accept the sample. tap[k] <= tap[k-1] for k>0.
//       tap[0] <= s_data. Working shifters sh[k] <= new tap[k]. bitcnt <= 0.
//       Next state is SEND.
//     - clear and s_valid in the same cycle: clear applies first, then the
//       shift. Result: tap[0]=s_data, all other taps 0.
//   - SEND: s_ready=0, m_valid=1, busy=1.
//     - m_bits[k] = sh[k][0].
//     - m_first = (bitcnt==0). m_last = (bitcnt==W-1).
//     - On m_valid && m_ready: sh[k] <= sh[k] >> 1 (zero-fill), and
//       bitcnt <= bitcnt+1.
//     - If the accepted beat had bitcnt==W-1, the next state is IDLE.
//     - clear is ignored in SEND.
//   Timing and throughput
//   - All m_* outputs are registered.
//   - Latency: sample accepted at edge n; first beat is valid in the cycle
//     after edge n.
//   - Beats hold stable while m_ready=0. No beat is dropped or duplicated.
//   - Throughput with m_ready tied to 1: one sample per W+1 cycles.
//   - bitcnt is ceil(log2(W)) bits wide and never wraps. The SEND exit is at
//     W-1.
//   Reset mid-operation
//   - Abort SEND. m_valid=0 in the cycle after the reset edge.
//   - Delay line returns to 0. The partial sample is discarded.
// TESTING  (W=3, L=3; m_bits shown as {tap2,tap1,tap0})
//   1. Reset, s_data=3'b101, m_ready=1
//      -> beats 001 (first), 000, 001 (last); then s_ready=1 again.
//   2. Then s_data=3'b011 (tap0=011, tap1=101, tap2=000)
//      -> beats 011 (first), 001, 010 (last).
//   3. Repeat test 2 with m_ready=0 for 2 cycles on beat 1
//      -> m_bits holds 001, m_first=0, m_last=0; no beat is lost.
//   4. In IDLE with taps loaded, clear=1 together with s_valid=1, s_data=3'b111
//      -> beats 001, 001, 001.
//   5. reset=1 during beat 1 of test 2
//      -> next cycle m_valid=0, busy=0; after release, s_data=3'b100 gives
//      beats 000, 000, 001.
//   6. s_valid held high, m_ready=1
//      -> s_ready pulses once every 4 cycles; the delay line shifts exactly
//      once per accepted sample.

Source files
------------

// File: rtl/da_bit_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : da_bit_tx_if
// Purpose  : Handshake bundle for the DA bit-serial front end. Carries the
//            parallel sample stream (s_*) into the block and the bit-vector
//            beat stream (m_*) out of it.
// Ports    : s_valid/s_ready/s_data  - sample stream, W bits per sample
//            m_valid/m_ready/m_bits  - beat stream, L bits per beat
//            m_first/m_last          - beat carries bit 0 / bit W-1
// Modports : slave  - the da_bit_tx side (consumes samples, produces beats)
//            master - the environment side (produces samples, consumes beats)
// Revision : 1.0 - initial release
// ============================================================================
interface da_bit_tx_if #(
    parameter int W = 3,
    parameter int L = 3
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [L-1:0] m_bits;
    logic         m_first;
    logic         m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_bits, m_first, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_bits, m_first, m_last
    );
endinterface
`default_nettype wire

// File: rtl/da_bit_tx.sv
`default_nettype none
// ============================================================================
// Module   : da_bit_tx
// Purpose  : Bit-serial front end for distributed-arithmetic sum-of-products.
//            Each accepted sample is pushed into an L-tap delay line, then the
//            whole line is streamed LSB-first, one L-bit vector per beat; bit k
//            of a beat is the current bit of tap k (the DA table address).
// Ports    : clk    - system clock, rising edge
//            reset  - synchronous reset, active-high
//            clear  - zero the delay line (only acted on in IDLE)
//            busy   - high while streaming a sample
//            bus    - da_bit_tx_if.slave: sample in, bit-vector beats out
// Revision : 1.0 - initial release
// ============================================================================
module da_bit_tx #(
    parameter int W = 3,
    parameter int L = 3
) (
    input  wire logic   clk,
    input  wire logic   reset,
    input  wire logic   clear,
    output logic        busy,
    da_bit_tx_if.slave  bus
);
    localparam int             CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   tap_q [L];
    logic [W-1:0]   tap_d [L];
    logic [W-1:0]   sh_q  [L];
    logic [W-1:0]   sh_d  [L];
    logic [CW-1:0]  bitcnt_q, bitcnt_d;
    logic           first_q, first_d;
    logic           last_q, last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            for (int k = 0; k < L; k++) begin
                tap_q[k] <= '0;
                sh_q[k]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            first_q  <= first_d;
            last_q   <= last_d;
            for (int k = 0; k < L; k++) begin
                tap_q[k] <= tap_d[k];
                sh_q[k]  <= sh_d[k];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        first_d  = first_q;
        last_d   = last_q;
        for (int k = 0; k < L; k++) begin
            tap_d[k] = tap_q[k];
            sh_d[k]  = sh_q[k];
        end

        case (state_q)
            IDLE: begin
                // Clear is applied before the shift, so a simultaneous clear
                // and sample leaves only the new sample in the line.
                if (clear) begin
                    for (int k = 0; k < L; k++) begin
                        tap_d[k] = '0;
                    end
                end
                if (bus.s_valid) begin
                    // Descending order so each tap takes its neighbour's
                    // pre-shift value.
                    for (int k = L - 1; k > 0; k--) begin
                        tap_d[k] = tap_d[k-1];
                    end
                    tap_d[0] = bus.s_data;
                    for (int k = 0; k < L; k++) begin
                        sh_d[k] = tap_d[k];
                    end
                    bitcnt_d = '0;
                    first_d  = 1'b1;
                    last_d   = (W == 1);
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (bus.m_ready) begin
                    for (int k = 0; k < L; k++) begin
                        sh_d[k] = sh_q[k] >> 1;
                    end
                    first_d = 1'b0;
                    if (bitcnt_q == LAST_CNT) begin
                        // Counter parks at W-1; it is reloaded on the next
                        // accepted sample, so it never wraps.
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        last_d   = ((bitcnt_q + 1'b1) == LAST_CNT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat bits come straight from the LSB of each working shifter flop.
    for (genvar k = 0; k < L; k++) begin : g_bits
        assign bus.m_bits[k] = sh_q[k][0];
    end

    assign bus.m_valid = (state_q == SEND);
    assign bus.m_first = first_q;
    assign bus.m_last  = last_q;
    assign bus.s_ready = (state_q == IDLE) && !reset;
    assign busy        = (state_q == SEND);
endmodule
`default_nettype wire

// File: tb/tb_da_bit_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_da_bit_tx
// Purpose  : Directed self-checking bench for da_bit_tx (W=3, L=3).
//            Beat vectors are written as {tap2,tap1,tap0}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_da_bit_tx;
    localparam int W = 3;
    localparam int L = 3;

    logic clk;
    logic reset;
    logic clear;
    logic busy;
    int   n_checks;
    int   n_fails;

    da_bit_tx_if #(.W(W), .L(L)) bus ();

    da_bit_tx #(.W(W), .L(L)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [2:0] bits,
                            input logic first, input logic last);
        chk({tag, " m_valid"}, {31'd0, bus.m_valid}, 32'd1);
        chk({tag, " m_bits"},  {29'd0, bus.m_bits},  {29'd0, bits});
        chk({tag, " m_first"}, {31'd0, bus.m_first}, {31'd0, first});
        chk({tag, " m_last"},  {31'd0, bus.m_last},  {31'd0, last});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " idle m_valid"}, {31'd0, bus.m_valid}, 32'd0);
        chk({tag, " idle busy"},    {31'd0, busy},        32'd0);
        chk({tag, " idle s_ready"}, {31'd0, bus.s_ready}, 32'd1);
    endtask

    // Accept one sample (optionally with clear) and check its three beats
    // with m_ready held high.
    task automatic run_sample(input string tag, input logic [2:0] d,
                              input logic clr, input logic [2:0] b0,
                              input logic [2:0] b1, input logic [2:0] b2);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        clear       = clr;
        tick();
        bus.s_valid = 1'b0;
        clear       = 1'b0;
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        chk({tag, " s_ready"}, {31'd0, bus.s_ready}, 32'd0);
        chk_beat({tag, " b0"}, b0, 1'b1, 1'b0);
        tick();
        chk_beat({tag, " b1"}, b1, 1'b0, 1'b0);
        tick();
        chk_beat({tag, " b2"}, b2, 1'b0, 1'b1);
        tick();
        chk_idle(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        reset       = 1'b1;
        clear       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst m_bits",  {29'd0, bus.m_bits},  32'd0);
        chk("rst m_first", {31'd0, bus.m_first}, 32'd0);
        chk("rst m_last",  {31'd0, bus.m_last},  32'd0);
        chk("rst busy",    {31'd0, busy},        32'd0);
        chk("rst s_ready", {31'd0, bus.s_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post-rst s_ready", {31'd0, bus.s_ready}, 32'd1);

        // 1: single sample 101 into an empty line
        run_sample("t1", 3'b101, 1'b0, 3'b001, 3'b000, 3'b001);
        // 2: 011 follows; tap1 now holds 101
        run_sample("t2", 3'b011, 1'b0, 3'b011, 3'b001, 3'b010);

        // 3: same as test 2 but stall two cycles on beat 1
        do_reset();
        run_sample("t3pre", 3'b101, 1'b0, 3'b001, 3'b000, 3'b001);
        bus.s_valid = 1'b1;
        bus.s_data  = 3'b011;
        tick();
        bus.s_valid = 1'b0;
        chk_beat("t3 b0", 3'b011, 1'b1, 1'b0);
        tick();
        bus.m_ready = 1'b0;
        chk_beat("t3 b1", 3'b001, 1'b0, 1'b0);
        tick();
        chk_beat("t3 hold1", 3'b001, 1'b0, 1'b0);
        tick();
        chk_beat("t3 hold2", 3'b001, 1'b0, 1'b0);
        bus.m_ready = 1'b1;
        tick();
        chk_beat("t3 b2", 3'b010, 1'b0, 1'b1);
        tick();
        chk_idle("t3");

        // 4: clear together with a sample leaves only the new sample
        run_sample("t4", 3'b111, 1'b1, 3'b001, 3'b001, 3'b001);

        // 5: reset during beat 1 aborts the sample and empties the line
        do_reset();
        run_sample("t5pre", 3'b101, 1'b0, 3'b001, 3'b000, 3'b001);
        bus.s_valid = 1'b1;
        bus.s_data  = 3'b011;
        tick();
        bus.s_valid = 1'b0;
        chk_beat("t5 b0", 3'b011, 1'b1, 1'b0);
        tick();
        chk_beat("t5 b1", 3'b001, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk("t5 abort m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("t5 abort busy",    {31'd0, busy},        32'd0);
        chk("t5 abort s_ready", {31'd0, bus.s_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("t5 release s_ready", {31'd0, bus.s_ready}, 32'd1);
        run_sample("t5", 3'b100, 1'b0, 3'b000, 3'b000, 3'b001);

        // 6: s_valid held high; one acceptance every 4 cycles
        //    line before: tap0=100. After 010: tap0=010,tap1=100,tap2=000.
        //    After 110: tap0=110,tap1=010,tap2=100.
        bus.s_valid = 1'b1;
        bus.s_data  = 3'b010;
        chk("t6 c0 s_ready", {31'd0, bus.s_ready}, 32'd1);
        tick();
        bus.s_data = 3'b110;
        chk("t6 c1 s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk_beat("t6 s0 b0", 3'b000, 1'b1, 1'b0);
        tick();
        chk("t6 c2 s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk_beat("t6 s0 b1", 3'b001, 1'b0, 1'b0);
        tick();
        chk("t6 c3 s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk_beat("t6 s0 b2", 3'b010, 1'b0, 1'b1);
        tick();
        chk("t6 c4 s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("t6 c4 m_valid", {31'd0, bus.m_valid}, 32'd0);
        tick();
        chk("t6 c5 s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk_beat("t6 s1 b0", 3'b000, 1'b1, 1'b0);
        tick();
        chk("t6 c6 s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk_beat("t6 s1 b1", 3'b011, 1'b0, 1'b0);
        tick();
        chk("t6 c7 s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk_beat("t6 s1 b2", 3'b101, 1'b0, 1'b1);
        bus.s_valid = 1'b0;
        tick();
        chk("t6 c8 s_ready", {31'd0, bus.s_ready}, 32'd1);
        tick();
        chk_idle("t6 end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
